// File: rtl/sipo_framer.sv
// sipo_framer: serial-in/parallel-out framer with a valid/ready output holding register.
//
// Shifts one serial bit per enabled clock. When a frame completes, the assembled word is moved
// into the holding register, co_o pulses for one cycle and out_valid_o is raised until the
// consumer accepts the word. A completed word that overwrites an unconsumed word sets the
// sticky overflow_o flag, which clears only on reset.
//
// Optional feature (macro SIPO_FRAMER_PARITY_EN): each frame is WIDTH data bits followed by one
// even-parity bit. The parity bit is not stored. parity_err_o reports the check on every
// completion, and the word is delivered even when its parity is bad.
//
// Ports:
//   clk_i          rising-edge clock
//   rst_ni         asynchronous active-low reset
//   en_i           shift enable; si_i is sampled only when en_i=1
//   si_i           serial data input
//   out_o          holding register, last completed word
//   co_o           one-cycle word-complete pulse
//   out_valid_o    holding register contains an unconsumed word
//   out_ready_i    consumer accepts the word when out_valid_o & out_ready_i
//   overflow_o     sticky: a completed word overwrote an unconsumed word
//   parity_err_o   (SIPO_FRAMER_PARITY_EN only) parity check result of the last frame
//   bit_cnt_o      bits received in the current frame
module sipo_framer #(
   parameter int unsigned WIDTH     = 8,
   parameter bit          MSB_FIRST = 1'b1,
   parameter int unsigned CNT_W     = $clog2(WIDTH + 1)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             en_i,
   input  logic             si_i,
   output logic [WIDTH-1:0] out_o,
   output logic             co_o,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic             overflow_o,
`ifdef SIPO_FRAMER_PARITY_EN
   output logic             parity_err_o,
`endif
   output logic [CNT_W-1:0] bit_cnt_o
);

`ifdef SIPO_FRAMER_PARITY_EN
   // The frame ends on the parity bit that follows the last data bit.
   localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WIDTH);
`else
   localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WIDTH - 1);
`endif

   logic [WIDTH-1:0] sreg_q, sreg_d;
   logic [WIDTH-1:0] out_q, out_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             co_q, co_d;
   logic             valid_q, valid_d;
   logic             ovf_q, ovf_d;
   logic [WIDTH-1:0] shifted;
   logic [WIDTH-1:0] word;
   logic             last;
`ifdef SIPO_FRAMER_PARITY_EN
   logic             par_q, par_d;
   logic             perr_q, perr_d;
`endif

   always_comb begin
      shifted = MSB_FIRST ? {sreg_q[WIDTH-2:0], si_i} : {si_i, sreg_q[WIDTH-1:1]};
      last    = en_i && (cnt_q == LastCnt);
      sreg_d  = sreg_q;
      cnt_d   = cnt_q;
      out_d   = out_q;
      valid_d = valid_q;
      ovf_d   = ovf_q;
      co_d    = last;
      word    = shifted;
`ifdef SIPO_FRAMER_PARITY_EN
      par_d   = par_q;
      perr_d  = perr_q;
`endif

      if (en_i) begin
         cnt_d = last ? '0 : cnt_q + CNT_W'(1);
`ifdef SIPO_FRAMER_PARITY_EN
         // The parity bit is checked but never shifted into the data word.
         word = sreg_q;
         if (last) begin
            par_d  = 1'b0;
            perr_d = par_q ^ si_i;
         end else begin
            sreg_d = shifted;
            par_d  = par_q ^ si_i;
         end
`else
         sreg_d = shifted;
`endif
      end

      // A consume and a completion on the same edge leave valid set with the new word.
      if (valid_q && out_ready_i) begin
         valid_d = 1'b0;
      end
      if (last) begin
         out_d   = word;
         valid_d = 1'b1;
         if (valid_q && !out_ready_i) begin
            ovf_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sreg_q  <= '0;
         out_q   <= '0;
         cnt_q   <= '0;
         co_q    <= 1'b0;
         valid_q <= 1'b0;
         ovf_q   <= 1'b0;
`ifdef SIPO_FRAMER_PARITY_EN
         par_q   <= 1'b0;
         perr_q  <= 1'b0;
`endif
      end else begin
         sreg_q  <= sreg_d;
         out_q   <= out_d;
         cnt_q   <= cnt_d;
         co_q    <= co_d;
         valid_q <= valid_d;
         ovf_q   <= ovf_d;
`ifdef SIPO_FRAMER_PARITY_EN
         par_q   <= par_d;
         perr_q  <= perr_d;
`endif
      end
   end

   assign out_o       = out_q;
   assign co_o        = co_q;
   assign out_valid_o = valid_q;
   assign overflow_o  = ovf_q;
   assign bit_cnt_o   = cnt_q;
`ifdef SIPO_FRAMER_PARITY_EN
   assign parity_err_o = perr_q;
`endif

endmodule

// File: tb/tb_sipo_framer.sv
// tb_sipo_framer: drives two framers (MSB-first and LSB-first) with the same serial stream and
// compares both against a frame-level reference model built from a queue of received bits.
module tb_sipo_framer;

   localparam int unsigned W     = 8;
   localparam int unsigned CNT_W = $clog2(W + 1);
`ifdef SIPO_FRAMER_PARITY_EN
   localparam int unsigned FrameLen = W + 1;
`else
   localparam int unsigned FrameLen = W;
`endif

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             en = 1'b0;
   logic             si = 1'b0;
   logic             rdy = 1'b0;
   logic [W-1:0]     out_m, out_l;
   logic             co_m, co_l, v_m, v_l, ov_m, ov_l;
   logic [CNT_W-1:0] cnt_m, cnt_l;
   logic             pe_m, pe_l;

   always #5 clk = ~clk;

   sipo_framer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .en_i         (en),
      .si_i         (si),
      .out_o        (out_m),
      .co_o         (co_m),
      .out_valid_o  (v_m),
      .out_ready_i  (rdy),
      .overflow_o   (ov_m),
`ifdef SIPO_FRAMER_PARITY_EN
      .parity_err_o (pe_m),
`endif
      .bit_cnt_o    (cnt_m)
   );

   sipo_framer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .en_i         (en),
      .si_i         (si),
      .out_o        (out_l),
      .co_o         (co_l),
      .out_valid_o  (v_l),
      .out_ready_i  (rdy),
      .overflow_o   (ov_l),
`ifdef SIPO_FRAMER_PARITY_EN
      .parity_err_o (pe_l),
`endif
      .bit_cnt_o    (cnt_l)
   );

`ifndef SIPO_FRAMER_PARITY_EN
   assign pe_m = 1'b0;
   assign pe_l = 1'b0;
`endif

   // Reference model state
   bit           frame[$];
   logic [W-1:0] exp_msb, exp_lsb;
   logic         exp_co, exp_valid, exp_ovf, exp_perr;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
   endtask

   task automatic model_reset();
      frame.delete();
      exp_msb   = '0;
      exp_lsb   = '0;
      exp_co    = 1'b0;
      exp_valid = 1'b0;
      exp_ovf   = 1'b0;
      exp_perr  = 1'b0;
   endtask

   // One clock edge of the model, using the inputs sampled at that edge.
   task automatic model_step();
      logic [W-1:0] wm, wl;
      bit p;
      exp_co = 1'b0;
      if (exp_valid && rdy) exp_valid = 1'b0;
      if (en) begin
         frame.push_back(si);
         if (frame.size() == FrameLen) begin
            wm = '0;
            wl = '0;
            p  = 1'b0;
            for (int i = 0; i < W; i++) begin
               wm[W-1-i] = frame[i];
               wl[i]     = frame[i];
            end
            for (int i = 0; i < FrameLen; i++) p ^= frame[i];
            if (exp_valid) exp_ovf = 1'b1;  // still valid here means it was not consumed
            exp_msb   = wm;
            exp_lsb   = wl;
            exp_valid = 1'b1;
            exp_co    = 1'b1;
            exp_perr  = p;
            frame.delete();
         end
      end
   endtask

   task automatic check_all();
      check("out_msb", 64'(out_m), 64'(exp_msb));
      check("out_lsb", 64'(out_l), 64'(exp_lsb));
      check("co_msb", 64'(co_m), 64'(exp_co));
      check("co_lsb", 64'(co_l), 64'(exp_co));
      check("valid_msb", 64'(v_m), 64'(exp_valid));
      check("valid_lsb", 64'(v_l), 64'(exp_valid));
      check("ovf_msb", 64'(ov_m), 64'(exp_ovf));
      check("ovf_lsb", 64'(ov_l), 64'(exp_ovf));
      check("cnt_msb", 64'(cnt_m), 64'(frame.size()));
      check("cnt_lsb", 64'(cnt_l), 64'(frame.size()));
`ifdef SIPO_FRAMER_PARITY_EN
      check("perr_msb", 64'(pe_m), 64'(exp_perr));
      check("perr_lsb", 64'(pe_l), 64'(exp_perr));
`endif
   endtask

   task automatic cycle(input bit e, input bit s, input bit r);
      en  = e;
      si  = s;
      rdy = r;
      @(posedge clk);
      model_step();
      #1;
      check_all();
   endtask

   // Asynchronous reset: outputs must clear before any clock edge.
   task automatic do_reset();
      rst_n = 1'b0;
      en    = 1'b0;
      rdy   = 1'b0;
      #1;
      model_reset();
      check("rst_out", 64'(out_m), 64'd0);
      check("rst_cnt", 64'(cnt_m), 64'd0);
      check("rst_valid", 64'(v_m), 64'd0);
      check_all();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   // Sends w MSB first; ready is r_body for all but the final frame bit, which uses r_last.
   task automatic send_word(input logic [W-1:0] w, input bit r_body, input bit r_last,
                            input bit par_ok);
      bit b;
      for (int i = 0; i < FrameLen; i++) begin
         if (i < W) b = w[W-1-i];
         else       b = (^w) ^ !par_ok;
         cycle(1'b1, b, (i == FrameLen - 1) ? r_last : r_body);
      end
   endtask

   initial begin
      logic [7:0] pat;
      pat = 8'hB6;

      do_reset();

      // Reset mid-frame after a word is already held
      send_word(8'hA5, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) cycle(1'b1, 1'($urandom_range(0, 1)), 1'b0);
      do_reset();

      send_word(8'hB6, 1'b0, 1'b0, 1'b1);
      check("plan_msb_b6", 64'(out_m), 64'h00B6);
      check("plan_lsb_6d", 64'(out_l), 64'h006D);
      check("plan_co", 64'(co_m), 64'd1);
      cycle(1'b0, 1'b0, 1'b0);
      check("plan_co_drop", 64'(co_m), 64'd0);

      // Enable gating: idle cycles with si=1 after bits 2, 4 and 6
      do_reset();
      for (int i = 0; i < 8; i++) begin
         cycle(1'b1, pat[7-i], 1'b0);
         if (i == 1 || i == 3 || i == 5) cycle(1'b0, 1'b1, 1'b0);
      end
`ifdef SIPO_FRAMER_PARITY_EN
      cycle(1'b1, ^pat, 1'b0);
`endif
      check("gate_out", 64'(out_m), 64'h00B6);
      check("gate_co", 64'(co_m), 64'd1);

      // Back-pressure then a single consume
      do_reset();
      send_word(8'hB6, 1'b0, 1'b0, 1'b1);
      send_word(8'hFF, 1'b0, 1'b0, 1'b1);
      check("bp_out", 64'(out_m), 64'h00FF);
      check("bp_valid", 64'(v_m), 64'd1);
      check("bp_ovf", 64'(ov_m), 64'd1);
      cycle(1'b0, 1'b0, 1'b1);
      check("bp_consumed", 64'(v_m), 64'd0);
      check("bp_ovf_sticky", 64'(ov_m), 64'd1);

      // Consume and complete on the same edge
      do_reset();
      send_word(8'hB6, 1'b0, 1'b0, 1'b1);
      send_word(8'h3C, 1'b0, 1'b1, 1'b1);
      check("sim_out", 64'(out_m), 64'h003C);
      check("sim_valid", 64'(v_m), 64'd1);
      check("sim_ovf", 64'(ov_m), 64'd0);

`ifdef SIPO_FRAMER_PARITY_EN
      do_reset();
      send_word(8'hB6, 1'b1, 1'b1, 1'b1);
      check("par_good", 64'(pe_m), 64'd0);
      send_word(8'hB6, 1'b1, 1'b1, 1'b0);
      check("par_bad", 64'(pe_m), 64'd1);
      check("par_bad_out", 64'(out_m), 64'h00B6);
`endif

      // Randomized traffic with one reset in the middle
      for (int n = 0; n < 600; n++) begin
         if (n == 300) do_reset();
         cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 2) == 0));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/sipo_framer.md
Name: sipo_framer

Overview:
- Parametrised serial-in/parallel-out framer: shifts one serial bit per enabled clock.
- After WIDTH bits, transfers the assembled word to an output holding register.
- Raises a one-cycle completion pulse and presents the word on a valid/ready handshake.
- Next generation of the 8-bit serial shift/carry block: adds configurable width, bit order, back-pressure and overflow detection; feeds downstream parallel consumers.

Parameters:
- WIDTH, 8, data word width in bits (2..64).
- MSB_FIRST, 1, 1: first received bit lands in out[WIDTH-1]; 0: first received bit lands in out[0].
- CNT_W, $clog2(WIDTH+1), width of bit counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous reset, active-low (0 = reset).
- en  in  1  shift enable; bit on si is sampled only when en=1.
- si  in  1  serial data input.
- out  out  WIDTH  holding register, last completed word.
- co  out  1  word-complete pulse, one cycle.
- out_valid  out  1  holding register contains an unconsumed word.
- out_ready  in  1  consumer accepts word when out_valid & out_ready at rising edge.
- overflow  out  1  sticky: a completed word was lost or overwrote an unconsumed word.
- bit_cnt  out  CNT_W  bits received in the current frame (0..WIDTH-1).

Behaviour:
- Reset (rst=0, async): shift reg=0, bit_cnt=0, out=0, co=0, out_valid=0, overflow=0. Release is synchronous to the next edge; no partial frame survives reset.
- en=0: shift register and bit_cnt hold; co=0 on the following cycle; the handshake still operates.
- en=1:
  - MSB_FIRST=1: sreg <= {sreg[WIDTH-2:0], si}.
  - MSB_FIRST=0: sreg <= {si, sreg[WIDTH-1:1]}.
  - bit_cnt increments.
- Completion edge (en=1 and bit_cnt==WIDTH-1):
  - out <= assembled word including the current si.
  - bit_cnt <= 0.
  - co=1 for exactly the next cycle.
  - out_valid <= 1.
- Latency: word is on out, with co=1 and out_valid=1, one cycle after the edge sampling its last bit.
- Back-to-back frames: no idle bit required; continuous en=1 yields a co pulse every WIDTH cycles.
- Handshake:
  - out_valid & out_ready with no completion: out_valid <= 0; out holds its value.
  - Completion while out_valid=1 and out_ready=0: out is overwritten with the new word, out_valid stays 1, overflow <= 1.
  - Completion while out_valid=1 and out_ready=1: the old word is consumed, the new word loads, out_valid stays 1, no overflow.
- overflow clears only on reset.
- out_ready is ignored when out_valid=0.

Optional Feature:
- Macro: SIPO_FRAMER_PARITY_EN.
- Defined:
  - Each frame is WIDTH data bits followed by one even-parity bit; bit_cnt spans 0..WIDTH.
  - Completion occurs on the parity bit; the parity bit is not stored in out.
  - Extra output port parity_err (1 bit), updated on each completion: 1 if the XOR of data bits and parity bit is 1. Reset value 0. A word with bad parity is still delivered.
- Undefined: no parity bit, no parity_err port; behaviour as above.

Test Plan:
- Reset mid-frame: WIDTH=8, shift 5 bits, pull rst=0 -> out=0, bit_cnt=0, out_valid=0 immediately without a clock. Then 8 bits 1,0,1,1,0,1,1,0 -> out=8'hB6, co pulse 1 cycle.
- Bit order: MSB_FIRST=0, same serial bits 1,0,1,1,0,1,1,0 -> out=8'h6D.
- Enable gating: 8 bits interleaved with 3 en=0 cycles carrying si=1 -> out=8'hB6, co exactly 11 cycles after first bit edge +1; bit_cnt frozen during en=0.
- Back-pressure: out_ready=0, send 8'hB6 then 8'hFF -> out=8'hFF, out_valid=1, overflow=1. Then out_ready=1 for one cycle -> out_valid=0, overflow stays 1.
- Simultaneous consume+complete: out_valid=1, out_ready=1 on the same edge the next word 8'h3C completes -> out=8'h3C, out_valid=1, overflow=0.
- Parity (macro defined): data 8'hB6 with parity bit 1 -> parity_err=0. Data 8'hB6 with parity bit 0 -> parity_err=1, out=8'hB6. Co every 9 enabled cycles.
